fetch_stage: RTL and testbench

Instruction fetch stage of the rv32 pipeline. It holds the program counter and issues word reads to a synchronous instruction memory with 1-cycle read latency. It buffers returned instructions with their PCs in a 2-entry queue and presents them to the decode stage over a valid/ready handshake. The execute stage can redirect the PC for branches and jumps; the redirect flushes all in-flight and buffered instructions.

---
 rtl/fetch_stage.sv | 102 ++++++++++
 tb/tb_fetch_stage.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the program counter, issues word reads to a
// 1-cycle-latency instruction memory, and buffers returned instructions in a
// two-entry queue that feeds decode. A redirect from execute reloads the PC
// and discards everything in flight or buffered.
//
// Decode handshake: an instruction transfers on a rising edge where
// valid && ready. While valid is high and ready is low, ir and pc are held
// stable. valid never depends on ready. When valid is low, ir shows a NOP
// and pc shows zero.
module fetch_stage #(
  parameter int                  PC_WIDTH = 9,
  parameter logic [PC_WIDTH-1:0] INIT_PC  = '0,
  parameter int                  DEPTH    = 2
) (
  input  logic                clk,
  input  logic                reset,
  output logic                imem_rd,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic [31:0]         imem_data,
  input  logic                redirect,
  input  logic [PC_WIDTH-1:0] target,
  output logic                valid,
  input  logic                ready,
  output logic [31:0]         ir,
  output logic [PC_WIDTH-1:0] pc
);

  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [2:0]  DEPTH_W = 3'(DEPTH);

  // Fetch address for the next read and the address of the read in flight.
  logic [PC_WIDTH-1:0] pc_reg;
  logic [PC_WIDTH-1:0] inflight_addr;
  logic                inflight;

  // Two-entry circular queue; single-bit pointers cover both slots.
  logic [1:0]          count;
  logic                rd_ptr;
  logic                wr_ptr;
  logic [31:0]         q_ir [0:1];
  logic [PC_WIDTH-1:0] q_pc [0:1];

  logic                pop;
  logic                push;
  logic [2:0]          occupancy;

  // Issue decision, queue head presentation and push/pop qualifiers.
  always_comb begin
    valid     = (count != 2'd0);
    pop       = valid & ready;
    // A response returning in a redirect cycle belongs to the old path.
    push      = inflight & ~redirect;
    // Slots that will still be claimed after this cycle's pop; a new read is
    // only allowed when its response is guaranteed a free slot.
    occupancy = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    imem_rd   = ~reset & ~redirect & (occupancy < DEPTH_W);
    imem_addr = pc_reg;
    ir        = valid ? q_ir[rd_ptr] : NOP;
    pc        = valid ? q_pc[rd_ptr] : '0;
  end

  // PC, in-flight tracking and queue bookkeeping; redirect flushes all of it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_reg        <= INIT_PC;
      inflight      <= 1'b0;
      inflight_addr <= '0;
      count         <= 2'd0;
      rd_ptr        <= 1'b0;
      wr_ptr        <= 1'b0;
    end else if (redirect) begin
      pc_reg   <= target;
      inflight <= 1'b0;
      count    <= 2'd0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
    end else begin
      inflight <= imem_rd;
      if (imem_rd) begin
        // Word address wraps naturally at 2^PC_WIDTH.
        pc_reg        <= pc_reg + 1'b1;
        inflight_addr <= pc_reg;
      end
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // Queue storage; contents are only meaningful while count covers the slot.
  always_ff @(posedge clk) begin
    if (push) begin
      q_ir[wr_ptr] <= imem_data;
      q_pc[wr_ptr] <= inflight_addr;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage. The reference model is transaction level: a queue
// of word addresses that were issued but not yet taken by decode, plus the
// address the next read must use. Memory word at address a is 0x100 + a.
module tb_fetch_stage;

  localparam int          PW  = 9;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          imem_rd;
  logic [PW-1:0] imem_addr;
  logic [31:0]   imem_data;
  logic          redirect = 1'b0;
  logic [PW-1:0] target = '0;
  logic          valid;
  logic          ready = 1'b0;
  logic [31:0]   ir;
  logic [PW-1:0] pc;

  int checks = 0;
  int errors = 0;

  // Scoreboard / reference model state.
  logic [PW-1:0] exp_q[$];   // issued addresses not yet accepted, oldest first
  logic [PW-1:0] acc_q[$];   // addresses accepted by decode
  logic [PW-1:0] next_issue;
  bit            last_issue;
  bit            exp_valid;
  bit            exp_rd;
  bit            exp_pop;
  logic [PW-1:0] exp_pc;
  logic [31:0]   exp_ir;

  fetch_stage #(.PC_WIDTH(PW), .INIT_PC('0), .DEPTH(2)) dut (
    .clk(clk), .reset(reset), .imem_rd(imem_rd), .imem_addr(imem_addr),
    .imem_data(imem_data), .redirect(redirect), .target(target),
    .valid(valid), .ready(ready), .ir(ir), .pc(pc)
  );

  // Clock.
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [PW-1:0] a);
    return 32'h0000_0100 + {23'b0, a};
  endfunction

  // Synchronous instruction memory, one cycle read latency.
  always @(posedge clk) begin
    if (imem_rd) imem_data <= mem_word(imem_addr);
  end

  task automatic model_reset();
    exp_q.delete();
    next_issue = '0;
    last_issue = 1'b0;
  endtask

  // Expected outputs for the current cycle from the model and current inputs.
  task automatic eval_model();
    int returned;
    returned  = exp_q.size() - (last_issue ? 1 : 0);
    exp_valid = (returned > 0);
    exp_pop   = exp_valid && ready;
    exp_rd    = !redirect && ((exp_q.size() - (exp_pop ? 1 : 0)) < 2);
    exp_pc    = exp_valid ? exp_q[0] : '0;
    exp_ir    = exp_valid ? mem_word(exp_q[0]) : NOP;
  endtask

  // Driver: cross one clock edge and advance the model with it.
  task automatic advance();
    eval_model();
    @(posedge clk);
    if (exp_pop) acc_q.push_back(exp_q[0]);
    if (redirect) begin
      exp_q.delete();
      next_issue = target;
      last_issue = 1'b0;
    end else begin
      if (exp_pop) void'(exp_q.pop_front());
      if (exp_rd) begin
        exp_q.push_back(next_issue);
        next_issue = next_issue + 1'b1;
      end
      last_issue = exp_rd;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({valid, ir, pc, imem_rd} !== {1'b0, NOP, {PW{1'b0}}, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got v=%b ir=%h pc=%h rd=%b, want v=0 ir=%h pc=0 rd=0", valid, ir, pc, imem_rd, NOP);
    end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_stream();
    ready = 1'b1;
    acc_q.delete();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); eval_model();
      checks++; if (imem_rd !== exp_rd) begin errors++; $display("FAIL stream_rd c%0d: got %b want %b", i, imem_rd, exp_rd); end
      if (exp_rd) begin checks++; if (imem_addr !== next_issue) begin errors++; $display("FAIL stream_addr c%0d: got %h want %h", i, imem_addr, next_issue); end end
      checks++; if ({valid, pc, ir} !== {exp_valid, exp_pc, exp_ir}) begin errors++; $display("FAIL stream_out c%0d: got v=%b pc=%h ir=%h want v=%b pc=%h ir=%h", i, valid, pc, ir, exp_valid, exp_pc, exp_ir); end
      if (i == 0) begin checks++; if (imem_addr !== 9'h000) begin errors++; $display("FAIL first_addr: got %h want 000", imem_addr); end end
      if (i == 2) begin checks++; if ({valid, pc, ir} !== {1'b1, 9'h000, 32'h100}) begin errors++; $display("FAIL first_valid: got v=%b pc=%h ir=%h want v=1 pc=000 ir=00000100", valid, pc, ir); end end
      advance();
    end
    for (int k = 0; k < acc_q.size(); k++) begin
      checks++;
      if (acc_q[k] !== PW'(k)) begin errors++; $display("FAIL stream_order #%0d: got %h want %h", k, acc_q[k], PW'(k)); end
    end
  endtask

  task automatic test_stall();
    logic [PW-1:0] start_pc;
    logic [PW-1:0] held_pc;
    logic [31:0]   held_ir;
    acc_q.delete();
    ready = 1'b0;
    @(negedge clk); eval_model();
    start_pc = exp_pc;
    held_pc  = pc;
    held_ir  = ir;
    checks++; if ({valid, pc, ir} !== {exp_valid, exp_pc, exp_ir}) begin errors++; $display("FAIL stall_entry: got v=%b pc=%h ir=%h want v=%b pc=%h ir=%h", valid, pc, ir, exp_valid, exp_pc, exp_ir); end
    advance();
    for (int i = 1; i < 6; i++) begin
      @(negedge clk); eval_model();
      checks++; if (imem_rd !== exp_rd) begin errors++; $display("FAIL stall_rd c%0d: got %b want %b", i, imem_rd, exp_rd); end
      checks++; if ({pc, ir} !== {held_pc, held_ir} || valid !== 1'b1) begin errors++; $display("FAIL stall_hold c%0d: got v=%b pc=%h ir=%h want v=1 pc=%h ir=%h", i, valid, pc, ir, start_pc, mem_word(start_pc)); end
      advance();
    end
    ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); eval_model();
      checks++; if (imem_rd !== exp_rd) begin errors++; $display("FAIL resume_rd c%0d: got %b want %b", i, imem_rd, exp_rd); end
      checks++; if ({valid, pc, ir} !== {exp_valid, exp_pc, exp_ir}) begin errors++; $display("FAIL resume_out c%0d: got v=%b pc=%h ir=%h want v=%b pc=%h ir=%h", i, valid, pc, ir, exp_valid, exp_pc, exp_ir); end
      advance();
    end
    checks++; if (acc_q.size() < 6) begin errors++; $display("FAIL stall_count: got %0d accepted want >=6", acc_q.size()); end
    for (int k = 0; k < acc_q.size(); k++) begin
      checks++;
      if (acc_q[k] !== PW'(start_pc + PW'(k))) begin errors++; $display("FAIL stall_order #%0d: got %h want %h", k, acc_q[k], PW'(start_pc + PW'(k))); end
    end
  endtask

  task automatic test_redirect();
    ready = 1'b0;
    for (int i = 0; i < 3; i++) advance();
    redirect = 1'b1; target = 9'h040;
    @(negedge clk);
    checks++; if (imem_rd !== 1'b0) begin errors++; $display("FAIL redir_no_issue: got rd=%b want 0", imem_rd); end
    advance();
    redirect = 1'b0; ready = 1'b1;
    acc_q.delete();
    @(negedge clk);
    checks++; if ({valid, imem_rd, imem_addr} !== {1'b0, 1'b1, 9'h040}) begin errors++; $display("FAIL redir_next: got v=%b rd=%b addr=%h want v=0 rd=1 addr=040", valid, imem_rd, imem_addr); end
    advance();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); eval_model();
      checks++; if ({valid, pc, ir} !== {exp_valid, exp_pc, exp_ir}) begin errors++; $display("FAIL redir_out c%0d: got v=%b pc=%h ir=%h want v=%b pc=%h ir=%h", i, valid, pc, ir, exp_valid, exp_pc, exp_ir); end
      advance();
    end
    checks++; if (acc_q.size() < 4) begin errors++; $display("FAIL redir_count: got %0d accepted want >=4", acc_q.size()); end
    for (int k = 0; k < acc_q.size(); k++) begin
      checks++;
      if (acc_q[k] !== PW'(9'h040 + PW'(k))) begin errors++; $display("FAIL redir_order #%0d: got %h want %h", k, acc_q[k], PW'(9'h040 + PW'(k))); end
    end
  endtask

  task automatic test_wrap();
    logic [PW-1:0] wrap_exp [4];
    wrap_exp = '{9'h1FE, 9'h1FF, 9'h000, 9'h001};
    ready = 1'b1; redirect = 1'b1; target = 9'h1FE;
    advance();
    redirect = 1'b0;
    acc_q.delete();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); eval_model();
      checks++; if ({valid, pc, ir} !== {exp_valid, exp_pc, exp_ir}) begin errors++; $display("FAIL wrap_out c%0d: got v=%b pc=%h ir=%h want v=%b pc=%h ir=%h", i, valid, pc, ir, exp_valid, exp_pc, exp_ir); end
      advance();
    end
    checks++; if (acc_q.size() < 4) begin errors++; $display("FAIL wrap_count: got %0d accepted want >=4", acc_q.size()); end
    for (int k = 0; k < 4 && k < acc_q.size(); k++) begin
      checks++;
      if (acc_q[k] !== wrap_exp[k]) begin errors++; $display("FAIL wrap_order #%0d: got %h want %h", k, acc_q[k], wrap_exp[k]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [PW-1:0] head;
    ready = 1'b1;
    for (int i = 0; i < 4; i++) advance();
    acc_q.delete();
    redirect = 1'b1; target = 9'h0A0;
    @(negedge clk); eval_model();
    head = exp_pc;
    checks++; if ({valid, pc} !== {1'b1, head}) begin errors++; $display("FAIL b2b_head: got v=%b pc=%h want v=1 pc=%h", valid, pc, head); end
    advance();
    target = 9'h0C0;
    @(negedge clk);
    checks++; if ({valid, imem_rd} !== 2'b00) begin errors++; $display("FAIL b2b_second: got v=%b rd=%b want v=0 rd=0", valid, imem_rd); end
    advance();
    redirect = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); eval_model();
      checks++; if ({valid, pc, ir} !== {exp_valid, exp_pc, exp_ir}) begin errors++; $display("FAIL b2b_out c%0d: got v=%b pc=%h ir=%h want v=%b pc=%h ir=%h", i, valid, pc, ir, exp_valid, exp_pc, exp_ir); end
      advance();
    end
    checks++; if (acc_q.size() < 3) begin errors++; $display("FAIL b2b_count: got %0d accepted want >=3", acc_q.size()); end
    for (int k = 0; k < acc_q.size(); k++) begin
      logic [PW-1:0] want;
      want = (k == 0) ? head : PW'(9'h0C0 + PW'(k - 1));
      checks++;
      if (acc_q[k] !== want) begin errors++; $display("FAIL b2b_order #%0d: got %h want %h", k, acc_q[k], want); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      ready    = ($urandom_range(0, 3) != 0);
      redirect = ($urandom_range(0, 19) == 0);
      target   = PW'($urandom);
      @(negedge clk); eval_model();
      checks++; if (imem_rd !== exp_rd) begin errors++; $display("FAIL rand_rd c%0d: got %b want %b", i, imem_rd, exp_rd); end
      if (exp_rd) begin checks++; if (imem_addr !== next_issue) begin errors++; $display("FAIL rand_addr c%0d: got %h want %h", i, imem_addr, next_issue); end end
      checks++; if ({valid, pc, ir} !== {exp_valid, exp_pc, exp_ir}) begin errors++; $display("FAIL rand_out c%0d: got v=%b pc=%h ir=%h want v=%b pc=%h ir=%h", i, valid, pc, ir, exp_valid, exp_pc, exp_ir); end
      advance();
    end
    redirect = 1'b0;
  endtask

  task automatic test_reset_mid();
    ready = 1'b1;
    for (int i = 0; i < 5; i++) advance();
    #3 reset = 1'b1;
    #2;
    checks++;
    if ({valid, ir, pc, imem_rd} !== {1'b0, NOP, {PW{1'b0}}, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset: got v=%b ir=%h pc=%h rd=%b, want v=0 ir=%h pc=0 rd=0", valid, ir, pc, imem_rd, NOP);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    acc_q.delete();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); eval_model();
      checks++; if (imem_rd !== exp_rd) begin errors++; $display("FAIL restart_rd c%0d: got %b want %b", i, imem_rd, exp_rd); end
      checks++; if ({valid, pc, ir} !== {exp_valid, exp_pc, exp_ir}) begin errors++; $display("FAIL restart_out c%0d: got v=%b pc=%h ir=%h want v=%b pc=%h ir=%h", i, valid, pc, ir, exp_valid, exp_pc, exp_ir); end
      advance();
    end
    checks++; if (acc_q.size() < 3) begin errors++; $display("FAIL restart_count: got %0d accepted want >=3", acc_q.size()); end
    for (int k = 0; k < acc_q.size(); k++) begin
      checks++;
      if (acc_q[k] !== PW'(k)) begin errors++; $display("FAIL restart_order #%0d: got %h want %h", k, acc_q[k], PW'(k)); end
    end
  endtask

  // Test sequence and final report.
  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_wrap();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
